// File: rtl/dcache_controller.sv
// Write-back, write-allocate controller for a 2-way, 16-set, 256-bit-line data cache.
// Hits complete combinationally; misses stall through an optional write-back, a refill and one settle cycle.
module dcache_controller (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         cpu_req_i,
    input  logic         cpu_write_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic [3:0]   sram_addr_o,
    output logic [24:0]  sram_tag_o,
    output logic [255:0] sram_data_o,
    output logic         sram_enable_o,
    output logic         sram_write_o,
    input  logic [24:0]  sram_tag_i,
    input  logic [255:0] sram_data_i,
    input  logic         sram_hit_i,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);
    localparam int IDX_W  = 4;
    localparam int TAG_W  = 23;
    localparam int LINE_W = 256;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} state_t;

    state_t              state_q, state_d;
    logic                mem_enable_d, mem_write_d;
    logic [31:0]         mem_addr_d;
    logic [LINE_W-1:0]   mem_data_d;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [2:0]          word_sel;

    assign idx      = cpu_addr_i[8:5];
    assign tag      = cpu_addr_i[31:9];
    assign word_sel = cpu_addr_i[4:2];

    assign sram_addr_o   = idx;
    assign sram_enable_o = cpu_req_i;

    function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                     input logic [2:0]        sel,
                                                     input logic [31:0]       word);
        logic [LINE_W-1:0] merged;
        merged = line;
        merged[{sel, 5'b00000} +: 32] = word;
        return merged;
    endfunction

    // mem_addr_o/mem_data_o double as the captured victim address and line
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_o <= mem_enable_d;
            mem_write_o  <= mem_write_d;
            mem_addr_o   <= mem_addr_d;
            mem_data_o   <= mem_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_o;
        mem_write_d  = mem_write_o;
        mem_addr_d   = mem_addr_o;
        mem_data_d   = mem_data_o;
        cpu_data_o   = '0;
        cpu_stall_o  = 1'b0;
        sram_write_o = 1'b0;
        sram_tag_o   = '0;
        sram_data_o  = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req_i) begin
                    if (sram_hit_i) begin
                        if (cpu_write_i) begin
                            sram_write_o = 1'b1;
                            sram_data_o  = merge_word(sram_data_i, word_sel, cpu_data_i);
                            sram_tag_o   = {2'b11, tag};
                        end else begin
                            cpu_data_o = sram_data_i[{word_sel, 5'b00000} +: 32];
                        end
                    end else begin
                        cpu_stall_o  = 1'b1;
                        mem_enable_d = 1'b1;
                        mem_data_d   = sram_data_i;
                        // Victim in the LRU way must be flushed first only if valid and dirty
                        if (sram_tag_i[24] && sram_tag_i[23]) begin
                            state_d     = WRITEBACK;
                            mem_write_d = 1'b1;
                            mem_addr_d  = {sram_tag_i[TAG_W-1:0], idx, 5'b00000};
                        end else begin
                            state_d     = REFILL;
                            mem_write_d = 1'b0;
                            mem_addr_d  = {tag, idx, 5'b00000};
                        end
                    end
                end
            end
            WRITEBACK: begin
                cpu_stall_o = 1'b1;
                if (mem_ack_i) begin
                    state_d     = REFILL;
                    mem_write_d = 1'b0;
                    mem_addr_d  = {tag, idx, 5'b00000};
                end
            end
            REFILL: begin
                cpu_stall_o = 1'b1;
                if (mem_ack_i) begin
                    sram_write_o = 1'b1;
                    sram_data_o  = mem_data_i;
                    sram_tag_o   = {2'b10, tag};
                    mem_enable_d = 1'b0;
                    state_d      = DONE;
                end
            end
            DONE: begin
                cpu_stall_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
